// File: rtl/output_deproc.sv
// Decodes offset-binary sample codes back to signed samples: offset removal, optional
// boxcar averaging, round-half-up scaling and saturation, delivered on a valid/ready stream.
module output_deproc #(
  parameter int unsigned IN_W       = 7,
  parameter int unsigned OUT_W      = 4,
  parameter int unsigned OFFSET     = 32,
  parameter int unsigned SHIFT      = 2,
  parameter int unsigned DECIM_LOG2 = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             clr_sat,
  output logic [7:0]       sat_count
);

  localparam int unsigned AW = IN_W + DECIM_LOG2;
  localparam int unsigned CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  // Two extra bits: one for the final add, one for the sign after offset removal.
  localparam int unsigned VW = AW + 2;
  localparam int unsigned TS = SHIFT + DECIM_LOG2;

  localparam logic [CW-1:0]        LAST   = CW'((2 ** DECIM_LOG2) - 1);
  localparam logic signed [VW-1:0] OFF_V  = VW'(OFFSET << DECIM_LOG2);
  localparam logic signed [VW-1:0] HALF_V = VW'((2 ** TS) / 2);
  localparam logic signed [VW-1:0] MAX_V  = VW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [VW-1:0] MIN_V  = ~MAX_V;

  logic [AW-1:0]        acc_q, acc_d, acc_base;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_base;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_W-1:0]     out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;
  logic [7:0]           sat_count_q, sat_count_d;

  logic                 accept, last_acc, xfer, clip;
  logic signed [VW-1:0] sum_s, v_s, r_s;
  logic [OUT_W-1:0]     res;

  assign in_ready  = (cnt_q != LAST) || !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

  // flush restarts the group before this cycle's code is folded in.
  always_comb begin
    acc_base = flush ? '0 : acc_q;
    cnt_base = flush ? '0 : cnt_q;
    last_acc = accept && (cnt_base == LAST);

    sum_s = VW'(acc_base) + VW'(in_data);
    v_s   = sum_s - OFF_V;
    r_s   = (v_s + HALF_V) >>> TS;

    clip = 1'b0;
    res  = r_s[OUT_W-1:0];
    if (r_s > MAX_V) begin
      clip = 1'b1;
      res  = MAX_V[OUT_W-1:0];
    end else if (r_s < MIN_V) begin
      clip = 1'b1;
      res  = MIN_V[OUT_W-1:0];
    end
  end

  always_comb begin
    acc_d       = acc_base;
    cnt_d       = cnt_base;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;

    if (accept) begin
      if (last_acc) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_base + AW'(in_data);
        cnt_d = cnt_base + CW'(1);
      end
    end

    if (last_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
      out_sat_d   = clip;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    if (clr_sat) begin
      sat_count_d = '0;
    end else if (last_acc && clip && (sat_count_q != 8'hff)) begin
      sat_count_d = sat_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

endmodule

// File: tb/tb_output_deproc.sv
// Scoreboard bench for output_deproc: one instance without averaging, one averaging 4 codes.
module tb_output_deproc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_sat, a_clr_sat;
  logic [6:0] a_in_data;
  logic [3:0] a_out_data;
  logic [7:0] a_sat_count;

  logic       b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_sat, b_clr_sat;
  logic [6:0] b_in_data;
  logic [3:0] b_out_data;
  logic [7:0] b_sat_count;

  output_deproc u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .flush     (a_flush),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_sat   (a_out_sat),
    .clr_sat   (a_clr_sat),
    .sat_count (a_sat_count)
  );

  output_deproc #(
    .DECIM_LOG2 (2)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .flush     (b_flush),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_sat   (b_out_sat),
    .clr_sat   (b_clr_sat),
    .sat_count (b_sat_count)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [4:0] a_q[$];
  logic [4:0] b_q[$];
  int         exp_sat_a = 0;
  int         b_cnt = 0;
  int         b_sum = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference decode: {sat, data}, straight from the arithmetic definition.
  function automatic logic [4:0] model(input int sum, input int d);
    int         v;
    int         r;
    logic       s;
    logic [3:0] dq;
    v = sum - (32 << d);
    r = (v + (1 << (1 + d))) >>> (2 + d);
    s = 1'b0;
    if (r > 7) begin
      r = 7;
      s = 1'b1;
    end else if (r < -8) begin
      r = -8;
      s = 1'b1;
    end
    dq = r[3:0];
    return {s, dq};
  endfunction

  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      check_eq("a_pending", a_q.size() > 0, 1);
      if (a_q.size() > 0) check_eq("a_out", {a_out_sat, a_out_data}, a_q.pop_front());
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      check_eq("b_pending", b_q.size() > 0, 1);
      if (b_q.size() > 0) check_eq("b_out", {b_out_sat, b_out_data}, b_q.pop_front());
    end
  end

  task automatic send_a(input logic [6:0] code);
    int         n;
    logic [4:0] m;
    n = 0;
    a_in_valid = 1'b1;
    a_in_data  = code;
    do begin
      @(negedge clk);
      n++;
    end while (!a_in_ready && n < 50);
    check_eq("a_accept", a_in_ready, 1);
    m = model(int'(code), 0);
    a_q.push_back(m);
    if (a_clr_sat) exp_sat_a = 0;
    else if (m[4] && exp_sat_a < 255) exp_sat_a++;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    check_eq("a_lat", a_out_valid, 1);
    check_eq("a_satcnt", a_sat_count, exp_sat_a);
  endtask

  task automatic send_b(input logic [6:0] code, input logic fl);
    int n;
    bit fin;
    n = 0;
    b_in_valid = 1'b1;
    b_in_data  = code;
    b_flush    = fl;
    do begin
      @(negedge clk);
      n++;
    end while (!b_in_ready && n < 50);
    check_eq("b_accept", b_in_ready, 1);
    if (fl) begin
      b_cnt = 0;
      b_sum = 0;
    end
    b_sum += int'(code);
    b_cnt++;
    fin = (b_cnt == 4);
    if (fin) begin
      b_q.push_back(model(b_sum, 2));
      b_cnt = 0;
      b_sum = 0;
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_flush    = 1'b0;
    if (fin) check_eq("b_lat", b_out_valid, 1);
    else check_eq("b_idle", b_out_valid, 0);
  endtask

  task automatic flush_b();
    b_flush = 1'b1;
    @(posedge clk);
    #1;
    b_flush = 1'b0;
    b_cnt = 0;
    b_sum = 0;
  endtask

  initial begin
    time t0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0; a_out_ready = 1'b1; a_clr_sat = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b1; b_clr_sat = 1'b0;

    #12;
    check_eq("rst_valid", a_out_valid, 0);
    check_eq("rst_data", {a_out_sat, a_out_data}, 0);
    check_eq("rst_satcnt", a_sat_count, 0);
    check_eq("rst_ready", a_in_ready, 1);
    check_eq("rst_b_valid", b_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full code sweep, then rounding and clipping corners.
    for (int i = 0; i < 16; i++) send_a(7'(i * 4));
    send_a(7'd2);
    send_a(7'd1);
    send_a(7'd62);
    send_a(7'd127);
    check_eq("a_sat2", a_sat_count, 2);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: output holds, final code stalls.
    a_out_ready = 1'b0;
    send_a(7'd20);
    a_in_valid = 1'b1;
    a_in_data  = 7'd24;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_ready", a_in_ready, 0);
      check_eq("bp_valid", a_out_valid, 1);
      check_eq("bp_hold", {a_out_sat, a_out_data}, 5'h0d);
    end
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    send_a(7'd24);
    t0 = $time;
    for (int i = 0; i < 4; i++) send_a(7'(28 + i * 4));
    check_eq("a_thruput", 32'($time - t0), 40);

    a_flush = 1'b1;
    send_a(7'd40);
    a_flush = 1'b0;

    // Averaging instance.
    send_b(7'd40, 1'b0);
    send_b(7'd41, 1'b0);
    send_b(7'd42, 1'b0);
    send_b(7'd43, 1'b0);
    send_b(7'd10, 1'b0);
    send_b(7'd20, 1'b0);
    flush_b();
    for (int i = 0; i < 4; i++) send_b(7'd0, 1'b0);
    send_b(7'd100, 1'b0);
    send_b(7'd5, 1'b1);
    for (int i = 0; i < 3; i++) send_b(7'd50, 1'b0);

    // Asynchronous reset mid-group and with a held output.
    send_b(7'd44, 1'b0);
    send_b(7'd44, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    send_a(7'd8);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", a_out_valid, 0);
    check_eq("arst_data", {a_out_sat, a_out_data}, 0);
    check_eq("arst_satcnt", a_sat_count, 0);
    check_eq("arst_b_valid", b_out_valid, 0);
    a_q.delete();
    b_q.delete();
    exp_sat_a = 0;
    b_cnt = 0;
    b_sum = 0;
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_b(7'd44, 1'b0);

    // sat_count clear priority and saturation at 255.
    send_a(7'd127);
    a_clr_sat = 1'b1;
    send_a(7'd127);
    a_clr_sat = 1'b0;
    check_eq("clr_prio", a_sat_count, 0);
    for (int i = 0; i < 300; i++) send_a(7'd127);
    check_eq("a_sat_max", a_sat_count, 255);

    repeat (4) @(posedge clk);
    #1;
    check_eq("a_drained", a_q.size(), 0);
    check_eq("b_drained", b_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
